// File: rtl/tree_compare_solver.sv
// tree_compare_solver
// Finds the unsigned minimum of a default value and every qualified channel
// value. The channels are reduced by a balanced binary tree, and the tree
// root is then compared against the default value.
//
// Build option:
//   TREE_COMPARE_SOLVER_REGISTERED_OUTPUT_EN
//     undefined -> result is combinational (zero latency, clk/reset unused)
//     defined   -> result is registered on clk, 1-cycle latency, and a
//                  synchronous active-high reset clears it to 0
module tree_compare_solver #(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_COUNT = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [DATA_WIDTH-1:0]               default_value,
    input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
    input  logic [CHANNEL_COUNT-1:0]            valids,
    output logic [DATA_WIDTH-1:0]               result
);

    localparam int LEVELS = $clog2(CHANNEL_COUNT);

    // Number of nodes at a given tree level. An odd node count at one level
    // leaves a lone node that passes straight up, which gives the rounding up.
    function automatic int nodeCount(input int level);
        int count;
        count = CHANNEL_COUNT;
        for (int k = 0; k < level; k++) begin
            count = (count + 1) / 2;
        end
        return count;
    endfunction

    logic [DATA_WIDTH-1:0] rootValue;
    logic                  rootValid;
    logic [DATA_WIDTH-1:0] result_d;

    // Level 0 holds the leaves. Each higher level pairs up the nodes of the
    // level below it. Invalid nodes always carry a value of zero, so an X on
    // an unqualified channel can never reach the output.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_level
        localparam int COUNT = nodeCount(l);

        logic [DATA_WIDTH-1:0] nodeValue [COUNT];
        logic                  nodeValid [COUNT];

        for (genvar j = 0; j < COUNT; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign nodeValid[j] = valids[j];
                assign nodeValue[j] = valids[j] ? values[j*DATA_WIDTH +: DATA_WIDTH]
                                                : '0;
            end else if (2*j + 1 < nodeCount(l - 1)) begin : g_pair
                logic [DATA_WIDTH-1:0] leftValue;
                logic [DATA_WIDTH-1:0] rightValue;
                logic                  leftValid;
                logic                  rightValid;

                assign leftValue  = g_level[l-1].nodeValue[2*j];
                assign rightValue = g_level[l-1].nodeValue[2*j + 1];
                assign leftValid  = g_level[l-1].nodeValid[2*j];
                assign rightValid = g_level[l-1].nodeValid[2*j + 1];

                // The right (higher-index) child wins only when it is valid and
                // strictly lower. Otherwise the left child is kept, so ties go to
                // the lower channel.
                assign nodeValid[j] = leftValid | rightValid;
                assign nodeValue[j] = (rightValid && (!leftValid || (rightValue < leftValue)))
                                      ? rightValue : leftValue;
            end else begin : g_pass
                assign nodeValid[j] = g_level[l-1].nodeValid[2*j];
                assign nodeValue[j] = g_level[l-1].nodeValue[2*j];
            end
        end
    end

    assign rootValue = g_level[LEVELS].nodeValue[0];
    assign rootValid = g_level[LEVELS].nodeValid[0];

    // Final stage: the default value wins unless a valid root is strictly lower.
    always_comb begin
        result_d = default_value;
        if (rootValid && (rootValue < default_value)) begin
            result_d = rootValue;
        end
    end

`ifdef TREE_COMPARE_SOLVER_REGISTERED_OUTPUT_EN
    logic [DATA_WIDTH-1:0] result_q;

    // Register the minimum. Reset clears the output to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;
`else
    logic unusedClockReset;

    assign unusedClockReset = clk ^ reset;
    assign result           = result_d;
`endif

endmodule

// File: tb/tb_tree_compare_solver.sv
// tb_tree_compare_solver
// Randomized and directed checks of tree_compare_solver against a plain
// minimum-over-a-set reference model. This bench works with both the
// combinational and the registered build
// (TREE_COMPARE_SOLVER_REGISTERED_OUTPUT_EN). Each stimulus is applied just
// after a rising edge and checked just after the following edge.
module tb_tree_compare_solver;

    localparam int DW = 8;
    localparam int CH = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     defaultValue;
    logic [DW*CH-1:0]  values;
    logic [CH-1:0]     valids;
    logic [DW-1:0]     result;

    int testCount = 0;
    int failCount = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    tree_compare_solver #(
        .DATA_WIDTH    (DW),
        .CHANNEL_COUNT (CH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .default_value (defaultValue),
        .values        (values),
        .valids        (valids),
        .result        (result)
    );

    // Reference model: the smallest member of {default} plus the valid channels.
    function automatic logic [DW-1:0] modelMin(input logic [DW-1:0]    d,
                                               input logic [DW*CH-1:0] v,
                                               input logic [CH-1:0]    vl);
        logic [DW-1:0] best;
        best = d;
        for (int i = 0; i < CH; i++) begin
            if (vl[i] && (v[i*DW +: DW] < best)) begin
                best = v[i*DW +: DW];
            end
        end
        return best;
    endfunction

    // Pack five channel values with channel 0 in the LSBs.
    function automatic logic [DW*CH-1:0] pack5(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                               input logic [DW-1:0] c2, input logic [DW-1:0] c3,
                                               input logic [DW-1:0] c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    // Count one comparison and report it if the values differ (X-aware).
    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: result=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive one input set just after an edge. Return just after the next edge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic [DW*CH-1:0] v,
                                 input logic [CH-1:0] vl);
        @(posedge clk);
        #1;
        defaultValue = d;
        values       = v;
        valids       = vl;
        @(posedge clk);
        #1;
    endtask

    // Apply a directed vector and compare against a fixed expected value.
    task automatic directedCase(input string tag, input logic [DW-1:0] d,
                                input logic [DW*CH-1:0] v, input logic [CH-1:0] vl,
                                input logic [DW-1:0] expected);
        applyStimulus(d, v, vl);
        checkOutput(tag, result, expected);
    endtask

    // Pick a channel value that lands on the extremes fairly often.
    function automatic logic [DW-1:0] randomValue();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return 8'h00;
        if (sel == 1) return 8'hFF;
        return DW'($urandom);
    endfunction

    // Main sequence: reset, directed vectors, reset behaviour, random vectors.
    initial begin
        logic [DW*CH-1:0] v;
        logic [CH-1:0]    vl;
        logic [DW-1:0]    d;
        logic [DW-1:0]    expected;

        reset        = 1'b1;
        defaultValue = 8'h33;
        values       = '0;
        valids       = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
`ifdef TREE_COMPARE_SOLVER_REGISTERED_OUTPUT_EN
        checkOutput("reset_state", result, 8'h00);
`else
        checkOutput("reset_state", result, 8'h33);
`endif
        reset = 1'b0;

        directedCase("all_invalid",  8'h33, pack5(8'h01, 8'h02, 8'h03, 8'h04, 8'h05), 5'b00000, 8'h33);
        directedCase("ch1_lower",    8'h33, pack5(8'h00, 8'h22, 8'h00, 8'h00, 8'h00), 5'b00010, 8'h22);
        directedCase("ch1_higher",   8'h33, pack5(8'h00, 8'h44, 8'h00, 8'h00, 8'h00), 5'b00010, 8'h33);
        directedCase("ch024",        8'h33, pack5(8'h44, 8'h00, 8'h11, 8'h00, 8'h88), 5'b10101, 8'h11);
        directedCase("ch4_only",     8'hAA, pack5(8'h44, 8'h00, 8'h11, 8'h00, 8'h88), 5'b10000, 8'h88);
        directedCase("all_high",     8'hFF, pack5(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB), 5'b11111, 8'hFB);
        directedCase("all_cleared",  8'hFF, pack5(8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB), 5'b00000, 8'hFF);
        directedCase("tie_default",  8'h40, pack5(8'h40, 8'h40, 8'h90, 8'h40, 8'h41), 5'b11111, 8'h40);
        directedCase("zero_ch3",     8'h01, pack5(8'h05, 8'h07, 8'h09, 8'h00, 8'h02), 5'b11111, 8'h00);

        v = pack5(8'h00, 8'hxx, 8'h10, 8'hxx, 8'h00);
        directedCase("x_invalid",    8'h20, v, 5'b00100, 8'h10);
        checkOutput("x_free", {7'b0, $isunknown(result)}, 8'h00);

`ifdef TREE_COMPARE_SOLVER_REGISTERED_OUTPUT_EN
        @(posedge clk);
        #1;
        reset        = 1'b1;
        defaultValue = 8'hFF;
        values       = pack5(8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        valids       = 5'b00001;
        @(posedge clk);
        #1;
        checkOutput("reset_clears", result, 8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after_reset", result, 8'h05);
`else
        @(posedge clk);
        #1;
        reset        = 1'b1;
        defaultValue = 8'hFF;
        values       = pack5(8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
        valids       = 5'b00001;
        #1;
        checkOutput("reset_ignored", result, 8'h05);
        @(posedge clk);
        #1;
        checkOutput("reset_ignored_edge", result, 8'h05);
        reset = 1'b0;
`endif

        for (int n = 0; n < 300; n++) begin
            d  = randomValue();
            vl = CH'($urandom);
            for (int i = 0; i < CH; i++) begin
                v[i*DW +: DW] = randomValue();
                if (!vl[i] && ($urandom_range(0, 3) == 0)) begin
                    v[i*DW +: DW] = 'x;
                end
            end
            expected = modelMin(d, v, vl);
            applyStimulus(d, v, vl);
            checkOutput("random", result, expected);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
